input_conditioner: RTL

Upstream conditioning stage for the memory-mapped switch/key/LED peripheral of the MIPS microsystem. It takes the raw, asynchronous, active-low board pins (two 32-bit DIP banks, 8 push keys), synchronises and debounces every bit, and presents clean, same-polarity vectors that the peripheral samples directly. It also produces per-key press pulses and sticky press flags for software polling or interrupt use.

---
 rtl/io_pkg.sv | 11 +
 rtl/input_conditioner_if.sv | 28 ++
 rtl/debounce_cell.sv | 52 +++++
 rtl/input_conditioner.sv | 81 ++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the switch/key input conditioning path.
package io_pkg;

    localparam int   NUM_DIP_BITS = 64;
    localparam int   NUM_KEYS     = 8;
    localparam int   DIP_BANK_W   = NUM_DIP_BITS / 2;

    // Level of an unpressed key / open DIP contact (pins are active-low).
    localparam logic PIN_IDLE     = 1'b1;

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side and software-side signal bundle of the input conditioner.
interface input_conditioner_if;
    import io_pkg::*;

    logic [DIP_BANK_W-1:0] dips0_3_raw;
    logic [DIP_BANK_W-1:0] dips4_7_raw;
    logic [NUM_KEYS-1:0]   key_raw;
    logic [NUM_KEYS-1:0]   key_ack;

    logic [DIP_BANK_W-1:0] dips0_3;
    logic [DIP_BANK_W-1:0] dips4_7;
    logic [NUM_KEYS-1:0]   key;
    logic [NUM_KEYS-1:0]   key_press;
    logic [NUM_KEYS-1:0]   key_pending;

    // Board pins and software acks drive the conditioner.
    modport master (
        output dips0_3_raw, dips4_7_raw, key_raw, key_ack,
        input  dips0_3, dips4_7, key, key_press, key_pending
    );

    // The conditioner itself.
    modport slave (
        input  dips0_3_raw, dips4_7_raw, key_raw, key_ack,
        output dips0_3, dips4_7, key, key_press, key_pending
    );

endinterface

// File: rtl/debounce_cell.sv
// Synchroniser plus per-bit tick-based debouncer for a W-bit pin vector.
module debounce_cell
    import io_pkg::*;
#(
    parameter int W              = 8,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);

    localparam int            CW   = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

    logic [W-1:0]         sync_p0;
    logic [W-1:0]         sync_p1;
    logic [W-1:0][CW-1:0] cnt;

    // Two-flop synchroniser; idles at the released pin level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= {W{PIN_IDLE}};
            sync_p1 <= {W{PIN_IDLE}};
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after STABLE_SAMPLES consecutive differing ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= {W{PIN_IDLE}};
            cnt    <= '0;
        end else if (tick) begin
            for (int i = 0; i < W; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    stable[i] <= sync_p1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounces DIP banks and keys; derives key press pulses and sticky flags.
module input_conditioner
    import io_pkg::*;
#(
    parameter int TICK_DIV       = 20000,
    parameter int STABLE_SAMPLES = 4
) (
    input logic                clk,
    input logic                reset,
    input_conditioner_if.slave bus
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]       ps_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] key_prev;

    assign tick    = (ps_cnt == PS_LAST);
    assign bus.key = key_stable;

    // Sample-tick prescaler, wraps in the cycle tick is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    debounce_cell #(
        .W              (DIP_BANK_W),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_dips0_3 (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .raw    (bus.dips0_3_raw),
        .stable (bus.dips0_3)
    );

    debounce_cell #(
        .W              (DIP_BANK_W),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_dips4_7 (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .raw    (bus.dips4_7_raw),
        .stable (bus.dips4_7)
    );

    debounce_cell #(
        .W              (NUM_KEYS),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_keys (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .raw    (bus.key_raw),
        .stable (key_stable)
    );

    // Falling-edge press pulse and sticky pending flags (a new press beats an ack).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev        <= {NUM_KEYS{PIN_IDLE}};
            bus.key_press   <= '0;
            bus.key_pending <= '0;
        end else begin
            key_prev        <= key_stable;
            bus.key_press   <= key_prev & ~key_stable;
            bus.key_pending <= (bus.key_pending & ~bus.key_ack) | bus.key_press;
        end
    end

endmodule
